// File: rtl/ahb_master_xfer.sv
// AHB-Lite bus master transfer engine.
// Takes one command (start address, direction, beat count) and issues a
// pipelined SINGLE or INCR burst of 32-bit words. Honours wait states and the
// two-cycle non-OKAY response, and reports completion with a done/err pulse.
module ahb_master_xfer #(
  parameter int LEN_W = 8
) (
  input  logic             hclk,
  input  logic             hreset,
  // command side
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic             cmd_write,
  input  logic [LEN_W-1:0] cmd_len,
  // local data side
  input  logic [31:0]      wr_data,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_resp,
  // AHB-Lite master side
  output logic [31:0]      haddr,
  output logic [1:0]       htrans,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [2:0]       hburst,
  output logic [31:0]      hwdata,
  input  logic [31:0]      hrdata,
  input  logic             hready,
  input  logic [1:0]       hresp
);

  localparam logic [1:0]   TR_IDLE   = 2'b00;
  localparam logic [1:0]   TR_NONSEQ = 2'b10;
  localparam logic [1:0]   TR_SEQ    = 2'b11;
  localparam logic [1:0]   RESP_OKAY = 2'b00;
  localparam logic [2:0]   BURST_SINGLE = 3'b000;
  localparam logic [2:0]   BURST_INCR   = 3'b001;
  localparam logic [2:0]   SIZE_WORD    = 3'b010;
  localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_ERR2 = 2'b10
  } state_t;

  state_t state, state_nxt;

  // Beat bookkeeping: addresses still to issue, data phases still to finish.
  logic [LEN_W:0] addr_left, addr_left_nxt;
  logic [LEN_W:0] data_left, data_left_nxt;

  // Data-phase tracking: stage p0 is the address phase on the bus, stage p1
  // is the data phase that follows an accepted address phase.
  logic           vld_p1, vld_p1_nxt;
  logic           wr_p1, wr_p1_nxt;

  // hresp value seen in the first cycle of a non-OKAY response.
  logic [1:0]     resp_cap, resp_cap_nxt;

  logic [31:0]    haddr_nxt;
  logic [1:0]     htrans_nxt;
  logic           hwrite_nxt;
  logic [2:0]     hburst_nxt;
  logic [31:0]    hwdata_nxt;
  logic [31:0]    rd_data_nxt;
  logic           rd_valid_nxt;
  logic           done_nxt;
  logic           err_nxt;
  logic [1:0]     err_resp_nxt;

  logic           data_bad;
  logic           data_ok;
  logic           addr_acc;
  logic [31:0]    addr_inc;

  assign cmd_ready = (state == S_IDLE);
  assign hsize     = SIZE_WORD;

  // A data phase ending with anything but OKAY, in either response cycle.
  assign data_bad = (state == S_BUS) && vld_p1 && (hresp != RESP_OKAY);
  assign data_ok  = (state == S_BUS) && vld_p1 && hready && (hresp == RESP_OKAY);

  // An address phase is taken by the slave when hready is high, unless the
  // concurrent data phase is failing: that address is dropped, not issued.
  assign addr_acc = (state == S_BUS) && (htrans != TR_IDLE) && hready && !data_bad;

  assign wr_ready = addr_acc && hwrite;
  assign addr_inc = haddr + 32'd4;

  // State register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic for the whole engine.
  always_comb begin
    state_nxt     = state;
    addr_left_nxt = addr_left;
    data_left_nxt = data_left;
    vld_p1_nxt    = vld_p1;
    wr_p1_nxt     = wr_p1;
    resp_cap_nxt  = resp_cap;
    haddr_nxt     = haddr;
    htrans_nxt    = htrans;
    hwrite_nxt    = hwrite;
    hburst_nxt    = hburst;
    hwdata_nxt    = hwdata;
    rd_data_nxt   = rd_data;
    rd_valid_nxt  = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    err_resp_nxt  = RESP_OKAY;

    case (state)
      S_IDLE: begin
        vld_p1_nxt = 1'b0;
        if (cmd_valid) begin
          state_nxt     = S_BUS;
          htrans_nxt    = TR_NONSEQ;
          haddr_nxt     = cmd_addr & 32'hFFFF_FFFC;
          hwrite_nxt    = cmd_write;
          hburst_nxt    = (cmd_len == '0) ? BURST_SINGLE : BURST_INCR;
          addr_left_nxt = {1'b0, cmd_len} + CNT_ONE;
          data_left_nxt = {1'b0, cmd_len} + CNT_ONE;
        end
      end

      S_BUS: begin
        if (data_bad) begin
          // Non-OKAY: stop issuing; any pending address phase is abandoned.
          htrans_nxt    = TR_IDLE;
          vld_p1_nxt    = 1'b0;
          addr_left_nxt = CNT_ZERO;
          if (hready) begin
            // Slave skipped the first response cycle; finish right away.
            state_nxt    = S_IDLE;
            done_nxt     = 1'b1;
            err_nxt      = 1'b1;
            err_resp_nxt = hresp;
          end else begin
            state_nxt    = S_ERR2;
            resp_cap_nxt = hresp;
          end
        end else if (hready) begin
          // Address phase (p0) advance.
          if (addr_acc) begin
            addr_left_nxt = addr_left - CNT_ONE;
            if (hwrite) begin
              hwdata_nxt = wr_data;
            end
            if (addr_left > CNT_ONE) begin
              haddr_nxt  = addr_inc;
              htrans_nxt = (addr_inc[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
            end else begin
              htrans_nxt = TR_IDLE;
            end
          end
          vld_p1_nxt = addr_acc;
          wr_p1_nxt  = hwrite;

          // Data phase (p1) completion.
          if (data_ok) begin
            data_left_nxt = data_left - CNT_ONE;
            if (!wr_p1) begin
              rd_data_nxt  = hrdata;
              rd_valid_nxt = 1'b1;
            end
            if (data_left == CNT_ONE) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end

      S_ERR2: begin
        htrans_nxt = TR_IDLE;
        if (hready) begin
          state_nxt    = S_IDLE;
          done_nxt     = 1'b1;
          err_nxt      = 1'b1;
          err_resp_nxt = resp_cap;
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        htrans_nxt = TR_IDLE;
        vld_p1_nxt = 1'b0;
      end
    endcase
  end

  // Registered bus, status and bookkeeping outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_left <= '0;
      data_left <= '0;
      vld_p1    <= 1'b0;
      wr_p1     <= 1'b0;
      resp_cap  <= RESP_OKAY;
      haddr     <= '0;
      htrans    <= TR_IDLE;
      hwrite    <= 1'b0;
      hburst    <= BURST_SINGLE;
      hwdata    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_resp  <= RESP_OKAY;
    end else begin
      addr_left <= addr_left_nxt;
      data_left <= data_left_nxt;
      vld_p1    <= vld_p1_nxt;
      wr_p1     <= wr_p1_nxt;
      resp_cap  <= resp_cap_nxt;
      haddr     <= haddr_nxt;
      htrans    <= htrans_nxt;
      hwrite    <= hwrite_nxt;
      hburst    <= hburst_nxt;
      hwdata    <= hwdata_nxt;
      rd_data   <= rd_data_nxt;
      rd_valid  <= rd_valid_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      err_resp  <= err_resp_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_master_xfer.sv
// Bench for ahb_master_xfer: a table of burst scenarios driven through a
// scripted AHB slave, with address/read-data scoreboards, plus hand-written
// sequences for the early-error and mid-burst reset cases.
module tb_ahb_master_xfer;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic [1:0]  err_resp;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  ahb_master_xfer #(.LEN_W(8)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err),
    .err_resp  (err_resp),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [7:0]  len;
    int          wait_beat;   // beat whose data phase is stretched, -1 none
    int          wait_n;      // number of wait cycles on that beat
    int          err_beat;    // beat whose data phase errors, -1 none
    logic [1:0]  err_code;
    int          exp_issued;  // address phases the slave should accept
    int          exp_rd;      // rd_valid pulses
    int          exp_wr;      // wr_ready pulses
    logic        exp_err;
    logic [1:0]  exp_resp;
  } scen_t;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
  } exp_addr_t;

  exp_addr_t   aq[$];
  logic [31:0] rq[$];
  scen_t       tbl[10];

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] rpat(input int k);
    return 32'hDEADBEEF + 32'(k) * 32'h0001_0001;
  endfunction

  function automatic logic [31:0] wpat(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm, input int act, input int exp);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %0d, wanted %0d", nm, act, exp);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_htrans"},   32'(htrans),   32'h0);
    chk({tag, "_haddr"},    haddr,         32'h0);
    chk({tag, "_hwrite"},   32'(hwrite),   32'h0);
    chk({tag, "_hburst"},   32'(hburst),   32'h0);
    chk({tag, "_hwdata"},   hwdata,        32'h0);
    chk({tag, "_rd_data"},  rd_data,       32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, "_done"},     32'(done),     32'h0);
    chk({tag, "_err"},      32'(err),      32'h0);
    chk({tag, "_err_resp"}, 32'(err_resp), 32'h0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'h0);
    chk({tag, "_cmd_ready"},32'(cmd_ready),32'h1);
    chk({tag, "_hsize"},    32'(hsize),    32'h2);
  endtask

  // Issue one command and play the slave until done (or a cycle budget).
  task automatic run_cmd(input scen_t s);
    int          beats, cyc, nonseq_cyc, done_cyc, err_cyc;
    int          pend, next_issue, waits, err_stage, n_wr, n_rd;
    bit          got_done;
    logic [31:0] a;
    logic [31:0] er;
    exp_addr_t   ea;

    beats = int'(s.len) + 1;
    cyc = 0; nonseq_cyc = -1; done_cyc = -1; err_cyc = -1;
    pend = -1; next_issue = 0; waits = s.wait_n; err_stage = 0;
    n_wr = 0; n_rd = 0; got_done = 1'b0;
    aq.delete();
    rq.delete();
    for (int i = 0; i < beats; i++) begin
      a    = (s.addr & 32'hFFFF_FFFC) + 32'(4 * i);
      ea.a = a;
      ea.t = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
      aq.push_back(ea);
    end

    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = s.addr; cmd_write = s.write; cmd_len = s.len;
    hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
    #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);

    while (!got_done && cyc < 300) begin
      @(negedge hclk);
      cmd_valid = 1'b0;
      hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
      if (pend >= 0) begin
        if (pend == s.err_beat) begin
          hresp  = s.err_code;
          hready = (err_stage == 1);
          if (err_stage == 0) err_cyc = cyc;
          err_stage++;
        end else if (pend == s.wait_beat && waits > 0) begin
          hready = 1'b0;
          waits--;
        end else begin
          hrdata = rpat(pend);
          if (!s.write) rq.push_back(rpat(pend));
        end
      end
      wr_data = wpat(next_issue);
      #1;

      if (rd_valid) begin
        n_rd++;
        if (rq.size() == 0) begin
          note_fail("rd_valid_unexpected", n_rd, s.exp_rd);
        end else begin
          er = rq.pop_front();
          chk("rd_data", rd_data, er);
        end
      end
      if (wr_ready) n_wr++;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("done_err",       32'(err),       32'(s.exp_err));
        chk("done_err_resp",  32'(err_resp),  32'(s.exp_resp));
        chk("done_cmd_ready", 32'(cmd_ready), 32'h1);
      end

      if (err_stage == 2 && pend >= 0) begin
        chk("htrans_err2", 32'(htrans), 32'h0);
        pend = -1;
      end else if (pend >= 0 && !hready && err_stage == 0) begin
        if (s.write) chk("hwdata_hold", hwdata, wpat(pend));
        if (aq.size() > 0 && htrans != 2'b00) chk("haddr_hold", haddr, aq[0].a);
      end else if (pend >= 0 && hready && err_stage == 0) begin
        if (s.write) chk("hwdata", hwdata, wpat(pend));
        pend = -1;
      end

      if (htrans != 2'b00 && hready && err_stage == 0) begin
        if (aq.size() == 0) begin
          note_fail("extra_beat", next_issue + 1, beats);
        end else begin
          ea = aq.pop_front();
          chk("haddr",    haddr,          ea.a);
          chk("htrans",   32'(htrans),    32'(ea.t));
          chk("hwrite",   32'(hwrite),    32'(s.write));
          chk("hburst",   32'(hburst),    (s.len == 8'd0) ? 32'h0 : 32'h1);
          chk("wr_ready", 32'(wr_ready),  32'(s.write));
          if (next_issue == 0) nonseq_cyc = cyc;
          pend = next_issue;
          next_issue++;
        end
      end
      cyc++;
    end

    if (!got_done) note_fail("done_timeout", cyc, 300);
    chk("beats_issued", 32'(next_issue), 32'(s.exp_issued));
    chk("rd_pulses",    32'(n_rd),       32'(s.exp_rd));
    chk("wr_pulses",    32'(n_wr),       32'(s.exp_wr));
    if (got_done && s.err_beat < 0 && s.wait_n == 0)
      chk("done_latency", 32'(done_cyc - nonseq_cyc), 32'(beats + 1));
    if (got_done && s.err_beat >= 0)
      chk("err_latency", 32'(done_cyc - err_cyc), 32'h2);

    @(negedge hclk);
    hready = 1'b1; hresp = 2'b00;
    #1;
    chk("done_pulse_end", 32'(done),      32'h0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("idle_htrans",    32'(htrans),    32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          addr          wr    len    wb  wn  eb  code   iss rd wr  err   resp
    tbl[0] = '{32'h0000_0100, 1'b0, 8'd0,  -1, 0, -1, 2'b00,  1,  1, 0, 1'b0, 2'b00};
    tbl[1] = '{32'h0000_0200, 1'b1, 8'd3,   1, 2, -1, 2'b00,  4,  0, 4, 1'b0, 2'b00};
    tbl[2] = '{32'h0000_03F8, 1'b0, 8'd2,  -1, 0, -1, 2'b00,  3,  3, 0, 1'b0, 2'b00};
    tbl[3] = '{32'h0000_1000, 1'b0, 8'd3,  -1, 0,  1, 2'b01,  2,  1, 0, 1'b1, 2'b01};
    tbl[4] = '{32'hFFFF_FFFC, 1'b1, 8'd1,  -1, 0, -1, 2'b00,  2,  0, 2, 1'b0, 2'b00};
    tbl[5] = '{32'h0000_0080, 1'b0, 8'd0,  -1, 0,  0, 2'b10,  1,  0, 0, 1'b1, 2'b10};
    tbl[6] = '{32'h0000_0600, 1'b1, 8'd2,  -1, 0,  2, 2'b11,  3,  0, 3, 1'b1, 2'b11};
    tbl[7] = '{32'h0000_03E0, 1'b0, 8'd15,  5, 3, -1, 2'b00, 16, 16, 0, 1'b0, 2'b00};
    tbl[8] = '{32'h0000_0700, 1'b1, 8'd3,  -1, 0,  0, 2'b01,  1,  0, 1, 1'b1, 2'b01};
    tbl[9] = '{32'h0000_0123, 1'b0, 8'd1,  -1, 0, -1, 2'b00,  2,  2, 0, 1'b0, 2'b00};

    hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_len = 8'd0;
    wr_data = 32'h0; hrdata = 32'h0; hready = 1'b1; hresp = 2'b00;
    @(negedge hclk);
    #1;
    chk_reset_values("rst");
    repeat (2) @(negedge hclk);
    hreset = 1'b0;

    for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

    // Non-OKAY with hready high in its first cycle: ends at once with err.
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b0; cmd_len = 8'd1;
    hready = 1'b1; hresp = 2'b00;
    @(negedge hclk);
    cmd_valid = 1'b0;
    #1;
    chk("pv_nonseq", 32'(htrans), 32'h2);
    @(negedge hclk);
    hready = 1'b1; hresp = 2'b01;
    #1;
    chk("pv_no_wr_ready", 32'(wr_ready), 32'h0);
    @(negedge hclk);
    hready = 1'b1; hresp = 2'b00;
    #1;
    chk("pv_done",     32'(done),     32'h1);
    chk("pv_err",      32'(err),      32'h1);
    chk("pv_err_resp", 32'(err_resp), 32'h1);
    chk("pv_rd_valid", 32'(rd_valid), 32'h0);
    chk("pv_htrans",   32'(htrans),   32'h0);
    @(negedge hclk);
    #1;
    chk("pv_done_end", 32'(done), 32'h0);

    // Reset asserted in the middle of a write burst.
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = 32'h500; cmd_write = 1'b1; cmd_len = 8'd7;
    hready = 1'b1; hresp = 2'b00; wr_data = 32'h1234_5678;
    @(negedge hclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge hclk);
    #1;
    chk("mid_htrans_seq", 32'(htrans), 32'h3);
    chk("mid_hwdata",     hwdata,      32'h1234_5678);
    hreset = 1'b1;
    #1;
    chk_reset_values("midrst");
    @(negedge hclk);
    hreset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      #1;
      chk("post_rst_no_done", 32'(done),   32'h0);
      chk("post_rst_htrans",  32'(htrans), 32'h0);
    end
    run_cmd(tbl[1]);
    run_cmd(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_xfer.md
# ahb_master_xfer

AHB-Lite style bus master transfer engine, the initiator that drives transfers into slave response logic (`hresp`/`hready` generators) elsewhere in the dome. It accepts one command at a time: start address, direction and beat count. It issues a pipelined SINGLE or INCR burst of 32-bit words, moves write data in and read data out, and honours wait states and the two-cycle non-OKAY response. Completion is reported with a status pulse.

## Interface

Parameters:
- `LEN_W`, 8, width of `cmd_len`; a burst carries `cmd_len + 1` beats, so 1 to 2^LEN_W beats.

Ports:
- `hclk` input 1: clock; all state changes on the rising edge.
- `hreset` input 1: reset, asynchronous and active-high.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_addr` input 32: start byte address, word aligned (bits [1:0] ignored and driven 0).
- `cmd_write` input 1: 1 = write burst, 0 = read burst.
- `cmd_len` input LEN_W: beats minus one.
- `wr_data` input 32: write data for the current beat; must be valid whenever `wr_ready` is high (no backpressure).
- `wr_ready` output 1: combinational; one-cycle pulse per write beat, consumes `wr_data`.
- `rd_data` output 32: registered read data.
- `rd_valid` output 1: one-cycle pulse per OKAY read beat.
- `done` output 1: one-cycle pulse at the end of a burst.
- `err` output 1: valid with `done`; 1 when the burst ended on a non-OKAY response.
- `err_resp` output 2: valid with `done`; the terminating `hresp` value, 00 when the burst ended normally.
- `haddr` output 32: AHB address.
- `htrans` output 2: IDLE=00, NONSEQ=10, SEQ=11.
- `hwrite` output 1: AHB transfer direction.
- `hsize` output 3: constant 3'b010 (word).
- `hburst` output 3: SINGLE=000 when `cmd_len`==0, INCR=001 otherwise.
- `hwdata` output 32: write data, registered.
- `hrdata` input 32: read data from the slave.
- `hready` input 1: transfer done / wait-state control.
- `hresp` input 2: OKAY=00, ERROR=01, RETRY=10, SPLIT=11.

## Operation

- All AHB outputs and status outputs are registered; `wr_ready` and `cmd_ready` are the only combinational outputs.
- **Reset values:** `htrans`=00, `haddr`=0, `hwrite`=0, `hburst`=000, `hwdata`=0, `rd_data`=0, `rd_valid`=0, `done`=0, `err`=0, `err_resp`=00, `wr_ready`=0, state IDLE so `cmd_ready`=1.
- **States:**
  - IDLE.
  - BUS: address and/or data phase outstanding.
  - ERR2: second cycle of a non-OKAY response.
- **Counters:**
  - `addr_left`: beats still to be issued.
  - `data_left`: beats still to complete.
  - Both are LEN_W+1 bits.
- **IDLE -> BUS** on command accept. The next cycle shows `htrans`=NONSEQ, `haddr`=`cmd_addr`, `hwrite`, `hburst`.
- **Address phase accepted** on a cycle with `htrans`!=IDLE and `hready`=1.
  - If the beat is a write: `wr_ready`=1 that cycle, and `hwdata`<=`wr_data`.
  - If beats remain: next cycle `haddr`+=4 and `htrans`=SEQ.
  - If no beats remain: next cycle `htrans`=IDLE.
- **1 KB boundary:** when the incremented address has bits [9:0]==0, `htrans`=NONSEQ instead of SEQ. This includes 32-bit wrap 0xFFFFFFFC -> 0x00000000.
- **Wait states:** while `hready`=0, `haddr`, `htrans`, `hwrite` and `hwdata` are held.
- **Data phase completes** on `hready`=1 with `hresp`=OKAY.
  - Reads: `rd_data`<=`hrdata` and `rd_valid`=1 next cycle.
  - Last beat: `done`=1, `err`=0, `err_resp`=00 next cycle, and the state returns to IDLE.
- **Non-OKAY response** (any of ERROR/RETRY/SPLIT) with `hready`=0 in the data phase moves the block to ERR2.
  - Next cycle `htrans`=IDLE; any pending address phase is dropped and never reissued.
  - Remaining `wr_ready` pulses are suppressed.
- **ERR2:** on `hready`=1, `done`=1, `err`=1, `err_resp`=captured `hresp` next cycle, then IDLE.
  - No `rd_valid` for the errored beat.
  - While `hready`=0, the block stays in ERR2.
- A non-OKAY response with `hready`=1 in the first cycle is a protocol violation. It is treated as the second cycle: terminate with `err`=1.
- **Reset mid-burst:** every output goes to its reset value immediately and no `done` is produced.

## Timing

- Command accept (edge N) -> first NONSEQ visible in cycle N+1.
- Zero wait states: an n-beat burst occupies n+1 bus cycles. `done` is asserted in cycle N+n+2; `cmd_ready` is high in the same cycle, and a new command can be accepted in that cycle.
- `done` coincides with the final `rd_valid` on reads.
- Error: first error cycle E, `htrans`=IDLE in E+1 (ERR2). If `hready`=1 in E+1, `done`/`err` are asserted in E+2.

## Test plan

- Single read at 0x100, `cmd_len`=0, `hready`=1, `hrdata`=0xDEADBEEF:
  - NONSEQ/SINGLE at 0x100.
  - `rd_valid` with `rd_data`=0xDEADBEEF and `done`=1, `err`=0 two cycles after the NONSEQ cycle.
- INCR write of 4 beats at 0x200, with `hready` low for 2 cycles on beat 2:
  - Addresses 0x200/204/208/20C; NONSEQ then SEQ.
  - Exactly 4 `wr_ready` pulses.
  - `hwdata` held during the wait states.
  - `done`=1, `err`=0.
- INCR read of 3 beats at 0x3F8:
  - Addresses 0x3F8 SEQ? no: 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ.
  - 3 `rd_valid` pulses.
- 4-beat read, ERROR response (`hresp`=01, `hready`=0 then 1) on beat 2:
  - `htrans`=IDLE in the second error cycle; beats 3-4 never issued.
  - One `rd_valid`.
  - `done`=1, `err`=1, `err_resp`=01.
- Wrap: 2-beat write at 0xFFFFFFFC -> second beat at 0x00000000 with NONSEQ; `done`, `err`=0.
- Reset asserted mid-burst:
  - Outputs go to reset values immediately, with no `done`.
  - `cmd_ready`=1 after release, and a new command completes normally.
